// File: rtl/mux_pkg.sv
// Shared constants and helpers for the pipelined channel mux tree.
package mux_pkg;

  localparam int DEF_N_CH = 16;
  localparam int DEF_DW   = 8;

  // Number of 4:1 levels needed to reduce n inputs to one (a trailing 2:1 counts as a level).
  function automatic int clog4(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v * 4;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_tree_stage.sv
// One registered reduction level: groups of RAD inputs collapse to one, steered by two
// (or one) select bits starting at LSB; the valid bit and full select tag ride along.
module mux_tree_stage
  import mux_pkg::*;
#(
  parameter int NIN = DEF_N_CH,
  parameter int DW  = DEF_DW,
  parameter int SW  = 4,
  parameter int LSB = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      i_vld,
  input  logic [SW-1:0]             i_sel,
  input  logic [NIN*DW-1:0]         i_data,
  output logic                      o_vld,
  output logic [SW-1:0]             o_sel,
  output logic [(NIN/((NIN==2)?2:4))*DW-1:0] o_data
);

  localparam int RAD  = (NIN == 2) ? 2 : 4;
  localparam int RB   = (RAD == 4) ? 2 : 1;
  localparam int NOUT = NIN / RAD;

  logic [RB-1:0]      w_idx;
  logic [NOUT*DW-1:0] w_mux;

  assign w_idx = i_sel[LSB +: RB];

  // Output g keeps the members of group g whose low select bits match.
  always_comb begin
    w_mux = '0;
    for (int g = 0; g < NOUT; g++)
      w_mux[g*DW +: DW] = i_data[(g*RAD + int'(w_idx))*DW +: DW];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_vld  <= 1'b0;
      o_sel  <= '0;
      o_data <= '0;
    end else if (en) begin
      o_vld  <= i_vld;
      o_sel  <= i_sel;
      o_data <= w_mux;
    end
  end

endmodule

// File: rtl/mux_tree_pipe.sv
// Pipelined N_CH:1 mux tree with explicit or round-robin select and a single global
// advance: every stage loads together whenever the output is empty or being drained.
module mux_tree_pipe
  import mux_pkg::*;
#(
  parameter int N_CH = DEF_N_CH,
  parameter int DW   = DEF_DW,
  localparam int SW  = $clog2(N_CH),
  localparam int NST = clog4(N_CH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SW-1:0]        in_sel,
  input  logic [N_CH*DW-1:0]   in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DW-1:0]        out_data,
  output logic [SW-1:0]        out_sel
);

  logic          w_adv;
  logic [SW-1:0] r_scan;
  logic [SW-1:0] w_esel;

  assign w_adv    = !out_valid || out_ready;
  assign in_ready = w_adv;
  assign w_esel   = mode ? r_scan : in_sel;

  // Leaving auto mode parks the scan at channel 0; bubbles do not advance it.
  always_ff @(posedge clk) begin
    if (rst || !mode)
      r_scan <= '0;
    else if (in_valid && w_adv)
      r_scan <= r_scan + 1'b1;
  end

  for (genvar s = 0; s < NST; s++) begin : g_st
    localparam int NIN  = N_CH >> (2*s);
    localparam int NOUT = NIN / ((NIN == 2) ? 2 : 4);

    logic                w_vi;
    logic [SW-1:0]       w_si;
    logic [NIN*DW-1:0]   w_di;
    logic                w_vo;
    logic [SW-1:0]       w_so;
    logic [NOUT*DW-1:0]  w_do;

    if (s == 0) begin : g_head
      assign w_vi = in_valid;
      assign w_si = w_esel;
      assign w_di = in_data;
    end else begin : g_link
      assign w_vi = g_st[s-1].w_vo;
      assign w_si = g_st[s-1].w_so;
      assign w_di = g_st[s-1].w_do;
    end

    mux_tree_stage #(
      .NIN (NIN),
      .DW  (DW),
      .SW  (SW),
      .LSB (2*s)
    ) u_stage (
      .clk    (clk),
      .rst    (rst),
      .en     (w_adv),
      .i_vld  (w_vi),
      .i_sel  (w_si),
      .i_data (w_di),
      .o_vld  (w_vo),
      .o_sel  (w_so),
      .o_data (w_do)
    );
  end

  assign out_valid = g_st[NST-1].w_vo;
  assign out_sel   = g_st[NST-1].w_so;
  assign out_data  = g_st[NST-1].w_do;

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Scoreboard bench: stimulus pushes expected beats, negedge monitors pop and compare.
module tb_mux_tree_pipe;

  typedef struct {
    logic [7:0] d;
    logic [5:0] s;
    int         c;
    bit         lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- main DUT: N_CH=16, DW=8
  logic         mode16 = 0, in_valid16 = 0, out_ready16 = 1;
  logic [3:0]   in_sel16 = 0;
  logic [127:0] in_data16 = '0;
  logic         in_ready16, out_valid16;
  logic [7:0]   out_data16;
  logic [3:0]   out_sel16;

  mux_tree_pipe #(.N_CH(16), .DW(8)) u_d16 (
    .clk(clk), .rst(rst), .mode(mode16), .in_valid(in_valid16), .in_ready(in_ready16),
    .in_sel(in_sel16), .in_data(in_data16), .out_valid(out_valid16),
    .out_ready(out_ready16), .out_data(out_data16), .out_sel(out_sel16));

  // ---------------- N_CH=2 and N_CH=32 builds
  logic         in_valid2 = 0, in_ready2, out_valid2;
  logic [0:0]   in_sel2 = 0, out_sel2;
  logic [15:0]  in_data2 = '0;
  logic [7:0]   out_data2;

  mux_tree_pipe #(.N_CH(2), .DW(8)) u_d2 (
    .clk(clk), .rst(rst), .mode(1'b0), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_sel(in_sel2), .in_data(in_data2), .out_valid(out_valid2),
    .out_ready(1'b1), .out_data(out_data2), .out_sel(out_sel2));

  logic         in_valid32 = 0, in_ready32, out_valid32;
  logic [4:0]   in_sel32 = 0, out_sel32;
  logic [255:0] in_data32 = '0;
  logic [7:0]   out_data32;

  mux_tree_pipe #(.N_CH(32), .DW(8)) u_d32 (
    .clk(clk), .rst(rst), .mode(1'b0), .in_valid(in_valid32), .in_ready(in_ready32),
    .in_sel(in_sel32), .in_data(in_data32), .out_valid(out_valid32),
    .out_ready(1'b1), .out_data(out_data32), .out_sel(out_sel32));

  exp_t q16[$];
  exp_t q2[$];
  exp_t q32[$];
  bit   lat_en = 1;

  // ---------------- monitors
  always @(negedge clk) begin
    exp_t e;
    if (out_valid16 === 1'b1) begin
      if (q16.size() == 0) chk("spurious16", 1, 0);
      else begin
        e = q16[0];
        chk("data16", {24'd0, out_data16}, {24'd0, e.d});
        chk("sel16", {28'd0, out_sel16}, {26'd0, e.s});
        if (out_ready16) begin
          if (e.lat) chk("lat16", cyc - e.c, 2);
          void'(q16.pop_front());
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (out_valid2 === 1'b1) begin
      if (q2.size() == 0) chk("spurious2", 1, 0);
      else begin
        e = q2.pop_front();
        chk("data2", {24'd0, out_data2}, {24'd0, e.d});
        chk("sel2", {31'd0, out_sel2}, {26'd0, e.s});
        chk("lat2", cyc - e.c, 1);
      end
    end
    if (in_valid2 && in_ready2)
      q2.push_back('{d: in_data2[in_sel2*8 +: 8], s: {5'd0, in_sel2}, c: cyc, lat: 1});
    if (out_valid32 === 1'b1) begin
      if (q32.size() == 0) chk("spurious32", 1, 0);
      else begin
        e = q32.pop_front();
        chk("data32", {24'd0, out_data32}, {24'd0, e.d});
        chk("sel32", {27'd0, out_sel32}, {26'd0, e.s});
        chk("lat32", cyc - e.c, 3);
      end
    end
    if (in_valid32 && in_ready32)
      q32.push_back('{d: in_data32[in_sel32*8 +: 8], s: {1'b0, in_sel32}, c: cyc, lat: 1});
  end

  // ---------------- stimulus helpers for the main DUT
  // Channel k carries base+k, so the expected byte is base+es.
  task automatic send16(input logic m, input logic [3:0] sel, input logic [3:0] es,
                        input logic [7:0] base);
    bit ok;
    @(posedge clk); #1;
    mode16   = m;
    in_sel16 = sel;
    for (int k = 0; k < 16; k++) in_data16[k*8 +: 8] = base + 8'(k);
    in_valid16 = 1'b1;
    ok = 0;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      if (in_ready16) begin
        q16.push_back('{d: base + {4'd0, es}, s: {2'd0, es}, c: cyc, lat: lat_en});
        ok = 1;
      end
    end
    if (!ok) chk("accept_timeout", 0, 1);
  endtask

  task automatic idle16(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      in_valid16 = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid16}, 0);
    chk("rst_out_data", {24'd0, out_data16}, 0);
    chk("rst_out_sel", {28'd0, out_sel16}, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", {31'd0, in_ready16}, 1);

    // explicit select, no stall
    send16(0, 4'd9,  4'd9,  8'h10);
    send16(0, 4'd0,  4'd0,  8'h20);
    send16(0, 4'd15, 4'd15, 8'h30);
    send16(0, 4'd3,  4'd3,  8'h40);
    send16(0, 4'd12, 4'd12, 8'hf8);
    idle16(4);

    // round-robin scan, 18 beats, in_sel is noise
    for (int i = 0; i < 18; i++)
      send16(1, 4'(i ^ 5), 4'(i % 16), 8'(i * 7));
    // bubbles must not advance the scan
    idle16(2);
    send16(1, 4'hA, 4'd2, 8'h55);

    // toggle 1 -> 0 -> 1: scan restarts at 0
    send16(1, 4'h0, 4'd3, 8'h60);
    send16(0, 4'd5, 4'd5, 8'h70);
    send16(1, 4'd9, 4'd0, 8'h80);
    send16(1, 4'd9, 4'd1, 8'h90);
    idle16(4);

    // backpressure: fill with out_ready low, hold 5 cycles, then stream
    lat_en = 0;
    @(posedge clk); #1 out_ready16 = 1'b0;
    send16(0, 4'd7,  4'd7,  8'ha0);
    send16(0, 4'd14, 4'd14, 8'hb0);
    idle16(1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_in_ready", {31'd0, in_ready16}, 0);
      chk("stall_out_valid", {31'd0, out_valid16}, 1);
    end
    @(posedge clk); #1 out_ready16 = 1'b1;
    send16(0, 4'd1,  4'd1,  8'hc0);
    send16(0, 4'd2,  4'd2,  8'hc4);
    send16(0, 4'd13, 4'd13, 8'hc8);
    send16(0, 4'd6,  4'd6,  8'hcc);
    idle16(5);
    chk("stall_drained", q16.size(), 0);
    lat_en = 1;

    // reset with two auto-mode beats in flight
    @(posedge clk); #1 mode16 = 1'b0;
    @(posedge clk); #1 out_ready16 = 1'b0;
    send16(1, 4'd4, 4'd0, 8'hd0);
    send16(1, 4'd4, 4'd1, 8'hd8);
    @(posedge clk); #1 in_valid16 = 1'b0; rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; q16.delete(); out_ready16 = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", {31'd0, out_valid16}, 0);
    chk("midrst_in_ready", {31'd0, in_ready16}, 1);
    send16(1, 4'd7, 4'd0, 8'he0);
    idle16(5);
    chk("main_drained", q16.size(), 0);

    // N_CH=2 / N_CH=32 against the reference model
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      in_valid2  = ($urandom_range(0, 3) != 0);
      in_sel2    = 1'($urandom);
      in_data2   = 16'($urandom);
      in_valid32 = ($urandom_range(0, 3) != 0);
      in_sel32   = 5'($urandom);
      for (int w = 0; w < 8; w++) in_data32[w*32 +: 32] = $urandom;
    end
    @(posedge clk); #1 in_valid2 = 1'b0; in_valid32 = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("d2_drained", q2.size(), 0);
    chk("d32_drained", q32.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
